// File: rtl/readout_stream_axis.sv
// Scans the FA readout memory once per readoutValid rising edge and streams every
// present entry as an AXI4-Stream beat (index on TUSER, payload on TDATA).
module readout_stream_axis #(
    parameter int ADDR_WIDTH    = 9,
    parameter int DATA_WIDTH    = 96,
    parameter int READ_LATENCY  = 1,
    parameter int OVERRUN_WIDTH = 16
) (
    input  logic                     sysClk,
    input  logic                     sysReset,
    input  logic                     readoutActive,
    input  logic                     readoutValid,
    output logic [ADDR_WIDTH-1:0]    readoutAddress,
    input  logic                     readoutPresent,
    input  logic [DATA_WIDTH-1:0]    readoutData,
    output logic                     mTVALID,
    input  logic                     mTREADY,
    output logic                     mTLAST,
    output logic [DATA_WIDTH-1:0]    mTDATA,
    output logic [ADDR_WIDTH-1:0]    mTUSER,
    output logic                     busy,
    output logic [ADDR_WIDTH:0]      packetCount,
    output logic [OVERRUN_WIDTH-1:0] overrunCount
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ADDR  = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_EVAL  = 3'd3;
    localparam logic [2:0] S_FLUSH = 3'd4;

    localparam logic [ADDR_WIDTH-1:0]    ADDR_LAST = '1;
    localparam logic [ADDR_WIDTH-1:0]    ADDR_ONE  = 1;
    localparam logic [ADDR_WIDTH:0]      CNT_ONE   = 1;
    localparam logic [OVERRUN_WIDTH-1:0] OVR_ONE   = 1;
    localparam logic [OVERRUN_WIDTH-1:0] OVR_MAX   = '1;
    localparam logic [1:0]               LAT_INIT  = 2'(READ_LATENCY - 1);
    localparam logic [1:0]               LAT_ONE   = 2'd1;

    logic [2:0]               state_q, state_d;
    logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
    logic [1:0]               lat_q, lat_d;
    logic                     busy_q, busy_d;
    logic                     rv_prev_q, rv_prev_d;
    logic                     hold_full_q, hold_full_d;
    logic [ADDR_WIDTH-1:0]    hold_idx_q, hold_idx_d;
    logic [DATA_WIDTH-1:0]    hold_data_q, hold_data_d;
    logic                     out_valid_q, out_valid_d;
    logic                     out_last_q, out_last_d;
    logic [ADDR_WIDTH-1:0]    out_user_q, out_user_d;
    logic [DATA_WIDTH-1:0]    out_data_q, out_data_d;
    logic [ADDR_WIDTH:0]      sent_cnt_q, sent_cnt_d;
    logic [ADDR_WIDTH:0]      last_cnt_q, last_cnt_d;
    logic [ADDR_WIDTH:0]      pkt_cnt_q, pkt_cnt_d;
    logic [OVERRUN_WIDTH-1:0] ovr_cnt_q, ovr_cnt_d;

    logic trigger;
    logic slot_free;
    logic scan_abort;
    logic eval_adv;

    assign rv_prev_d  = readoutValid;
    assign trigger    = readoutValid && !rv_prev_q && !readoutActive;
    assign slot_free  = !out_valid_q || mTREADY;
    assign scan_abort = readoutActive &&
                        (state_q == S_ADDR || state_q == S_WAIT || state_q == S_EVAL);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        lat_d       = lat_q;
        busy_d      = busy_q;
        hold_full_d = hold_full_q;
        hold_idx_d  = hold_idx_q;
        hold_data_d = hold_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_user_d  = out_user_q;
        out_data_d  = out_data_q;
        sent_cnt_d  = sent_cnt_q;
        last_cnt_d  = last_cnt_q;
        pkt_cnt_d   = pkt_cnt_q;
        ovr_cnt_d   = ovr_cnt_q;
        eval_adv    = 1'b0;

        if (out_valid_q && mTREADY) begin
            out_valid_d = 1'b0;
            if (out_last_q) pkt_cnt_d = last_cnt_q;
        end

        if (scan_abort) begin
            // The held entry still goes out via FLUSH so the packet is closed with TLAST.
            if (ovr_cnt_q != OVR_MAX) ovr_cnt_d = ovr_cnt_q + OVR_ONE;
            state_d = S_FLUSH;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (trigger) begin
                        addr_d     = '0;
                        busy_d     = 1'b1;
                        sent_cnt_d = '0;
                        state_d    = S_ADDR;
                    end
                end
                S_ADDR: begin
                    lat_d   = LAT_INIT;
                    state_d = (READ_LATENCY == 1) ? S_EVAL : S_WAIT;
                end
                S_WAIT: begin
                    lat_d = lat_q - LAT_ONE;
                    if (lat_q == LAT_ONE) state_d = S_EVAL;
                end
                S_EVAL: begin
                    eval_adv = 1'b1;
                    if (readoutPresent) begin
                        if (!hold_full_q) begin
                            hold_full_d = 1'b1;
                            hold_idx_d  = addr_q;
                            hold_data_d = readoutData;
                        end else if (slot_free) begin
                            out_valid_d = 1'b1;
                            out_last_d  = 1'b0;
                            out_user_d  = hold_idx_q;
                            out_data_d  = hold_data_q;
                            sent_cnt_d  = sent_cnt_q + CNT_ONE;
                            hold_idx_d  = addr_q;
                            hold_data_d = readoutData;
                        end else begin
                            // Address stays put, so the memory output remains valid next cycle.
                            eval_adv = 1'b0;
                        end
                    end
                    if (eval_adv) begin
                        if (addr_q == ADDR_LAST) begin
                            state_d = S_FLUSH;
                        end else begin
                            addr_d  = addr_q + ADDR_ONE;
                            state_d = S_ADDR;
                        end
                    end
                end
                S_FLUSH: begin
                    if (hold_full_q) begin
                        if (slot_free) begin
                            out_valid_d = 1'b1;
                            out_last_d  = 1'b1;
                            out_user_d  = hold_idx_q;
                            out_data_d  = hold_data_q;
                            last_cnt_d  = sent_cnt_q + CNT_ONE;
                            sent_cnt_d  = '0;
                            hold_full_d = 1'b0;
                            busy_d      = 1'b0;
                            state_d     = S_IDLE;
                        end
                    end else begin
                        pkt_cnt_d  = '0;
                        sent_cnt_d = '0;
                        busy_d     = 1'b0;
                        state_d    = S_IDLE;
                    end
                end
                default: begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge sysClk or posedge sysReset) begin
        if (sysReset) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            lat_q       <= '0;
            busy_q      <= 1'b0;
            rv_prev_q   <= 1'b0;
            hold_full_q <= 1'b0;
            hold_idx_q  <= '0;
            hold_data_q <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_user_q  <= '0;
            out_data_q  <= '0;
            sent_cnt_q  <= '0;
            last_cnt_q  <= '0;
            pkt_cnt_q   <= '0;
            ovr_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            lat_q       <= lat_d;
            busy_q      <= busy_d;
            rv_prev_q   <= rv_prev_d;
            hold_full_q <= hold_full_d;
            hold_idx_q  <= hold_idx_d;
            hold_data_q <= hold_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_user_q  <= out_user_d;
            out_data_q  <= out_data_d;
            sent_cnt_q  <= sent_cnt_d;
            last_cnt_q  <= last_cnt_d;
            pkt_cnt_q   <= pkt_cnt_d;
            ovr_cnt_q   <= ovr_cnt_d;
        end
    end

    assign readoutAddress = addr_q;
    assign mTVALID        = out_valid_q;
    assign mTLAST         = out_last_q;
    assign mTDATA         = out_data_q;
    assign mTUSER         = out_user_q;
    assign busy           = busy_q;
    assign packetCount    = pkt_cnt_q;
    assign overrunCount   = ovr_cnt_q;

endmodule
